clap_src: RTL and testbench
===========================

CLAP_SRC -- requirements
Module: clap_src

Interface
REQ-001 Parameter LEAD, default 2, cycles en is high before the first din_rvs pulse (>=1).
REQ-002 Parameter PW, default 3, din_rvs high cycles per pulse (>=1).
REQ-003 Parameter GAP, default 2, din_rvs low cycles between pulses, en held high (>=1).
REQ-004 Parameter CNT_W, default 8, width of pulse-count fields.
REQ-005 Reset rst_n, asynchronous, active-low; clock clk.
REQ-006 clk  input  1  rising-edge clock for all state.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 start  input  1  one-cycle request to generate a burst, sampled only in IDLE.
REQ-009 num  input  CNT_W  pulses in the burst, captured with start.
REQ-010 en  output  1  enable window to the downstream detector, registered.
REQ-011 din_rvs  output  1  pulse train to the downstream detector, registered.
REQ-012 busy  output  1  high while a burst is in progress.
REQ-013 done  output  1  one-cycle pulse at burst end.

Function
REQ-014 en, din_rvs, busy and done SHALL come directly from flops; no combinational path from any input to any output.
REQ-015 FSM states: IDLE, LEAD, PULSE, GAP, TAIL.
REQ-016 IDLE: start=1 with num>0 SHALL capture num and enter LEAD next cycle; en=1, busy=1 from that cycle.
REQ-017 IDLE: start=1 with num=0 SHALL stay in IDLE and assert done for one cycle on the next cycle; en never asserts.
REQ-018 LEAD SHALL last exactly LEAD cycles with en=1, din_rvs=0, then enter PULSE.
REQ-019 PULSE SHALL last exactly PW cycles with en=1, din_rvs=1; then GAP if pulses remain, else TAIL.
REQ-020 GAP SHALL last exactly GAP cycles with en=1, din_rvs=0, then PULSE.
REQ-021 TAIL SHALL last exactly 2 cycles with en=1, din_rvs=0, covering the detector's 2-cycle latency; then IDLE.
REQ-022 On the first IDLE cycle after TAIL: en=0, busy=0, done=1 for exactly one cycle.
REQ-023 Total en-high cycles SHALL equal LEAD + num*PW + (num-1)*GAP + 2.
REQ-024 start while busy=1 SHALL be ignored; num changes while busy SHALL not affect the burst.
REQ-025 start on the done cycle SHALL be accepted (back-to-back bursts; en low exactly one cycle between).
REQ-026 num = 2^CNT_W-1 SHALL complete without counter wrap.

Reset
REQ-027 rst_n low SHALL force IDLE, en=0, din_rvs=0, busy=0, done=0, all counters 0, asynchronously.
REQ-028 Reset mid-burst SHALL abort with no done pulse; first start after release begins a fresh burst.

Configuration
REQ-029 Macro CLAP_SRC_FLAG_CHECK_EN: when defined, adds ports flag (input 1, detector result), flag_cnt (output CNT_W), err (output 1).
REQ-030 With macro: flag_cnt SHALL clear on accepted start and count rising edges of flag (registered edge detect) until done.
REQ-031 With macro: on done, err SHALL become 1 if flag_cnt != captured num, else 0; err holds until next accepted start or reset; reset value 0.
REQ-032 Without macro: flag, flag_cnt, err ports and checking logic SHALL be absent; generator behaviour unchanged.

Verification
REQ-033 LEAD=2,PW=3,GAP=2, start with num=2 at cycle 0 -> en high cycles 1-12, din_rvs high 3-5 and 8-10, busy 1-12, done at cycle 13.
REQ-034 Same burst with macro, real detector (flag high 5-7, 10-12) -> flag_cnt=2, err=0 at cycle 13.
REQ-035 Macro defined, flag forced 0 throughout, num=2 -> err=1 at cycle 13, held until next start.
REQ-036 start with num=0 -> done at next cycle, en and din_rvs stay 0, busy stays 0.
REQ-037 start pulsed during PULSE state; rst_n low at cycle 6 of a num=3 burst -> start ignored; outputs 0 immediately on reset, no done.
REQ-038 start asserted on done cycle of a num=1 burst -> en low one cycle, second burst timing identical to first.

Source files
------------

// File: rtl/clap_src.sv
// clap_src: registered burst generator driving en/din_rvs into a detector.
// Optional flag-count self check is enabled by defining CLAP_SRC_FLAG_CHECK_EN.
module clap_src #(
  parameter int LEAD  = 2,
  parameter int PW    = 3,
  parameter int GAP   = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num,
`ifdef CLAP_SRC_FLAG_CHECK_EN
  input  logic             flag,
  output logic [CNT_W-1:0] flag_cnt,
  output logic             err,
`endif
  output logic             en,
  output logic             din_rvs,
  output logic             busy,
  output logic             done
);

  localparam int M1 = (LEAD > PW) ? LEAD : PW;
  localparam int M2 = (M1 > GAP) ? M1 : GAP;
  localparam int M3 = (M2 > 2) ? M2 : 2;
  localparam int CW = $clog2(M3 + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAD,
    S_PULSE,
    S_GAP,
    S_TAIL
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cyc_q, cyc_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             en_q, en_d;
  logic             din_q, din_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             acc;

  assign acc = (state_q == S_IDLE) && start;

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (num != '0) begin
            state_d = S_LEAD;
            rem_d   = num;
            cyc_d   = '0;
          end else begin
            done_d  = 1'b1;
          end
        end
      end
      S_LEAD: begin
        if (cyc_q == CW'(LEAD - 1)) begin
          state_d = S_PULSE;
          cyc_d   = '0;
        end else begin
          cyc_d   = cyc_q + 1'b1;
        end
      end
      S_PULSE: begin
        if (cyc_q == CW'(PW - 1)) begin
          // rem counts down from num, so 255 never wraps
          rem_d   = rem_q - 1'b1;
          state_d = (rem_q == 1) ? S_TAIL : S_GAP;
          cyc_d   = '0;
        end else begin
          cyc_d   = cyc_q + 1'b1;
        end
      end
      S_GAP: begin
        if (cyc_q == CW'(GAP - 1)) begin
          state_d = S_PULSE;
          cyc_d   = '0;
        end else begin
          cyc_d   = cyc_q + 1'b1;
        end
      end
      S_TAIL: begin
        if (cyc_q == CW'(1)) begin
          state_d = S_IDLE;
          cyc_d   = '0;
          done_d  = 1'b1;
        end else begin
          cyc_d   = cyc_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cyc_d   = '0;
      end
    endcase
    // outputs follow the next state so they leave the flops aligned
    en_d   = (state_d != S_IDLE);
    din_d  = (state_d == S_PULSE);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cyc_q   <= '0;
      rem_q   <= '0;
      en_q    <= 1'b0;
      din_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      rem_q   <= rem_d;
      en_q    <= en_d;
      din_q   <= din_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign en      = en_q;
  assign din_rvs = din_q;
  assign busy    = busy_q;
  assign done    = done_q;

`ifdef CLAP_SRC_FLAG_CHECK_EN
  logic             fprev_q, fprev_d;
  logic [CNT_W-1:0] fcnt_q, fcnt_d;
  logic [CNT_W-1:0] num_q, num_d;
  logic [CNT_W-1:0] cap;
  logic             err_q, err_d;

  always_comb begin
    fprev_d = flag;
    fcnt_d  = fcnt_q;
    num_d   = num_q;
    err_d   = err_q;
    if (acc) begin
      fcnt_d = '0;
      num_d  = num;
    end else if ((state_q != S_IDLE) && flag && !fprev_q) begin
      fcnt_d = fcnt_q + 1'b1;
    end
    cap = acc ? num : num_q;
    if (done_d) begin
      err_d = (fcnt_d != cap);
    end else if (acc) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fprev_q <= 1'b0;
      fcnt_q  <= '0;
      num_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      fprev_q <= fprev_d;
      fcnt_q  <= fcnt_d;
      num_q   <= num_d;
      err_q   <= err_d;
    end
  end

  assign flag_cnt = fcnt_q;
  assign err      = err_q;
`endif

endmodule

// File: tb/tb_clap_src.sv
// tb_clap_src: directed self-checking bench for clap_src.
// Flag-check scenarios run when CLAP_SRC_FLAG_CHECK_EN is defined.
module tb_clap_src;
  localparam int L = 2;
  localparam int P = 3;
  localparam int G = 2;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] num = '0;
  logic         en, din_rvs, busy, done;
  int           checks = 0;
  int           errors = 0;
  int           e1, e2;

`ifdef CLAP_SRC_FLAG_CHECK_EN
  logic         flag;
  logic [W-1:0] flag_cnt;
  logic         err;
  logic         d1 = 1'b0;
  logic         d2 = 1'b0;
  logic         det_on = 1'b0;
  always @(posedge clk) begin
    d1 <= din_rvs;
    d2 <= d1;
  end
  assign flag = det_on & d2;
`endif

  clap_src #(.LEAD(L), .PW(P), .GAP(G), .CNT_W(W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .num(num),
`ifdef CLAP_SRC_FLAG_CHECK_EN
    .flag(flag),
    .flag_cnt(flag_cnt),
    .err(err),
`endif
    .en(en),
    .din_rvs(din_rvs),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] exp_vec(input int c, input int n);
    int t, o;
    logic e, d, dn;
    t  = L + n * P + (n - 1) * G + 2;
    e  = (c >= 1) && (c <= t);
    dn = (c == t + 1);
    o  = c - 1 - L;
    d  = (o >= 0) && (o < n * (P + G) - G) && ((o % (P + G)) < P);
    return {e, d, e, dn};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic burst(input int n, input int spur, output int en_cnt);
    int t;
    logic [3:0] got, want;
    t = L + n * P + (n - 1) * G + 2;
    en_cnt = 0;
    num = W'(n);
    start = 1'b1;
    for (int c = 1; c <= t + 1; c++) begin
      step();
      start = (c == spur);
      if (c == 3) num = ~num;
      got  = {en, din_rvs, busy, done};
      want = exp_vec(c, n);
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL burst n=%0d cyc=%0d got=%b want=%b", n, c, got, want);
      end
      if (en) en_cnt++;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    checks++;
    if ({en, din_rvs, busy, done} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_hold got=%b want=0000", {en, din_rvs, busy, done});
    end
    rst_n = 1'b1;
    step();
    step();
    checks++;
    if ({en, din_rvs, busy, done} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_idle got=%b want=0000", {en, din_rvs, busy, done});
    end
  endtask

  task automatic test_basic();
    burst(2, 4, e1);
    checks++;
    if (e1 !== 12) begin
      errors++;
      $display("FAIL basic_en_cnt got=%0d want=12", e1);
    end
    step();
  endtask

  task automatic test_zero();
    num = '0;
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if ({en, din_rvs, busy, done} !== 4'b0001) begin
      errors++;
      $display("FAIL zero_done got=%b want=0001", {en, din_rvs, busy, done});
    end
    step();
    checks++;
    if ({en, din_rvs, busy, done} !== 4'b0000) begin
      errors++;
      $display("FAIL zero_after got=%b want=0000", {en, din_rvs, busy, done});
    end
    step();
  endtask

  task automatic test_abort();
    logic [3:0] got;
    num = W'(3);
    start = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      step();
      start = (c == 4);
      got = {en, din_rvs, busy, done};
      checks++;
      if (got !== exp_vec(c, 3)) begin
        errors++;
        $display("FAIL abort_pre cyc=%0d got=%b want=%b", c, got, exp_vec(c, 3));
      end
    end
    start = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({en, din_rvs, busy, done} !== 4'b0000) begin
      errors++;
      $display("FAIL abort_async got=%b want=0000", {en, din_rvs, busy, done});
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({en, din_rvs, busy, done} !== 4'b0000) begin
        errors++;
        $display("FAIL abort_hold i=%0d got=%b want=0000", i, {en, din_rvs, busy, done});
      end
    end
    rst_n = 1'b1;
    step();
    checks++;
    if ({en, din_rvs, busy, done} !== 4'b0000) begin
      errors++;
      $display("FAIL abort_nodone got=%b want=0000", {en, din_rvs, busy, done});
    end
    burst(1, 0, e1);
    step();
  endtask

  task automatic test_back_to_back();
    burst(1, 0, e1);
    burst(1, 0, e2);
    checks++;
    if (e1 !== 7 || e2 !== 7) begin
      errors++;
      $display("FAIL b2b_en_cnt got=%0d,%0d want=7,7", e1, e2);
    end
    step();
  endtask

  task automatic test_max();
    burst(255, 100, e1);
    checks++;
    if (e1 !== 1277) begin
      errors++;
      $display("FAIL max_en_cnt got=%0d want=1277", e1);
    end
    step();
  endtask

`ifdef CLAP_SRC_FLAG_CHECK_EN
  task automatic test_flag();
    det_on = 1'b1;
    burst(2, 0, e1);
    checks++;
    if (flag_cnt !== W'(2) || err !== 1'b0) begin
      errors++;
      $display("FAIL flag_ok cnt=%0d err=%b want cnt=2 err=0", flag_cnt, err);
    end
    step();
    det_on = 1'b0;
    step();
    step();
    burst(2, 0, e1);
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL flag_err got=%b want=1", err);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (err !== 1'b1) begin
        errors++;
        $display("FAIL flag_hold i=%0d got=%b want=1", i, err);
      end
    end
    num = W'(1);
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL flag_clear got=%b want=0", err);
    end
    for (int i = 0; i < 8; i++) step();
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_abort();
    test_back_to_back();
    test_max();
`ifdef CLAP_SRC_FLAG_CHECK_EN
    test_flag();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
